imu_accel_sequencer: RTL and testbench

Sequences the I2C `master_controller` to read the IMU's six accelerometer registers (0x12–0x17) in one burst at a fixed sample rate. It assembles the bytes into signed 16-bit X/Y/Z samples and publishes them with a one-cycle valid strobe. It sits between the `simp` top level and the I2C master, and owns every master input except `clk`.

---
 rtl/simp_pkg.sv | 33 +++
 rtl/imu_accel_sequencer_period_timer.sv | 31 +++
 rtl/imu_accel_sequencer.sv | 176 +++++++++++++++++
 tb/tb_imu_accel_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simp_pkg.sv
// Shared definitions for the simp IMU front end: sequencer state encoding,
// IMU register map constants and a helper for burst register addressing.
package simp_pkg;

  // Sequencer state encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE    = 2'd0;
  localparam seq_state_t ST_ISSUE   = 2'd1;
  localparam seq_state_t ST_XFER    = 2'd2;
  localparam seq_state_t ST_PUBLISH = 2'd3;

  // IMU bus address and accelerometer register map
  localparam logic [6:0] IMU_ADDR = 7'h68;
  localparam logic [6:0] ACCX_LSB = 7'h12;
  localparam logic [6:0] ACCX_MSB = 7'h13;
  localparam logic [6:0] ACCY_LSB = 7'h14;
  localparam logic [6:0] ACCY_MSB = 7'h15;
  localparam logic [6:0] ACCZ_LSB = 7'h16;
  localparam logic [6:0] ACCZ_MSB = 7'h17;

  // Direction bit handed to the I2C master for a register read
  localparam logic I2C_READ = 1'b1;

  // A burst is six bytes: X, Y, Z, each LSB first
  localparam logic [2:0] LAST_BYTE_IDX = 3'd5;

  // Register address of byte 'idx' within a burst starting at 'base'
  function automatic logic [6:0] acc_reg_addr(input logic [6:0] base,
                                              input logic [2:0] idx);
    return base + {4'b0000, idx};
  endfunction

endpackage

// File: rtl/imu_accel_sequencer_period_timer.sv
// period_timer: free-running sample-rate divider that only counts while
// enabled. The first tick lands SAMPLE_PERIOD cycles after enable rises,
// and dropping enable returns the count to zero.
module period_timer #(
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST_COUNT);

  // Count enabled cycles, wrapping on each tick and clearing when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imu_accel_sequencer.sv
// imu_accel_sequencer: drives the I2C master_controller to read the six
// accelerometer bytes in one burst per sample period, assembles signed
// 16-bit X/Y/Z samples and publishes them with a one-cycle strobe.
// Optional feature macro: IMU_SEQ_TIMEOUT_EN adds a per-byte watchdog that
// aborts a stalled burst and raises the sticky 'error' flag.
module imu_accel_sequencer #(
  parameter logic [6:0] IMU_ADDR       = simp_pkg::IMU_ADDR,
  parameter logic [6:0] ACC_BASE_ADDR  = simp_pkg::ACCX_LSB,
  parameter int         SAMPLE_PERIOD  = 100000,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        i2c_start,
  output logic        i2c_read_write,
  output logic [6:0]  i2c_slave_addr,
  output logic [6:0]  i2c_reg_addr,
  output logic [7:0]  i2c_data_in,
  input  logic [7:0]  i2c_data_out,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
  output logic        sample_valid,
  output logic        overrun,
  output logic        error
);

  import simp_pkg::*;

  seq_state_t       state;
  logic [2:0]       idx;
  logic [5:0][7:0]  slots;
  logic             tick;
  logic             pending;
  logic             take_tick;
  logic             timeout_hit;

  assign i2c_read_write = I2C_READ;
  assign i2c_slave_addr = IMU_ADDR;
  assign i2c_data_in    = 8'h00;

  assign take_tick = (state == ST_IDLE) && pending && enable;

  period_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_period_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  // Remember one outstanding tick; a new tick wins over the IDLE consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end else if (take_tick) begin
      pending <= 1'b0;
    end
  end

  // Sticky overrun: a tick arrived while an earlier one was still waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (tick && pending && !take_tick) begin
      overrun <= 1'b1;
    end
  end

`ifdef IMU_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;

  assign timeout_hit = (state == ST_XFER) && !i2c_done &&
                       (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on the current byte; restart on every done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if ((state != ST_XFER) || i2c_done) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WD_W'(1);
    end
  end

  // Sticky timeout flag, cleared by the next successful publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (timeout_hit) begin
      error <= 1'b1;
    end else if (state == ST_PUBLISH) begin
      error <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign timeout_hit    = 1'b0;
  assign error          = 1'b0;
`endif

  // Burst sequencer: issue each byte, capture it, publish all three axes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      i2c_start    <= 1'b0;
      i2c_reg_addr <= '0;
      sample_valid <= 1'b0;
      slots        <= '0;
      acc_x        <= '0;
      acc_y        <= '0;
      acc_z        <= '0;
    end else begin
      i2c_start    <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_tick) begin
            state        <= ST_ISSUE;
            idx          <= '0;
            i2c_reg_addr <= acc_reg_addr(ACC_BASE_ADDR, 3'd0);
          end
        end
        ST_ISSUE: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (!i2c_busy) begin
            i2c_start <= 1'b1;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (i2c_done) begin
            slots[idx] <= i2c_data_out;
            if (!enable) begin
              state <= ST_IDLE;
            end else if (idx == LAST_BYTE_IDX) begin
              state <= ST_PUBLISH;
            end else begin
              idx          <= idx + 3'd1;
              i2c_reg_addr <= acc_reg_addr(ACC_BASE_ADDR, idx + 3'd1);
              state        <= ST_ISSUE;
            end
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_PUBLISH: begin
          acc_x        <= {slots[1], slots[0]};
          acc_y        <= {slots[3], slots[2]};
          acc_z        <= {slots[5], slots[4]};
          sample_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_accel_sequencer.sv
// Testbench for imu_accel_sequencer: behavioural I2C master, expected
// register-address and sample scoreboards, one task per scenario.
module tb_imu_accel_sequencer;

  localparam int PERIOD = 200;
  localparam int TMO    = 50;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        i2c_start;
  logic        i2c_read_write;
  logic [6:0]  i2c_slave_addr;
  logic [6:0]  i2c_reg_addr;
  logic [7:0]  i2c_data_in;
  logic [7:0]  i2c_data_out;
  logic        i2c_busy;
  logic        i2c_done;
  logic [15:0] acc_x;
  logic [15:0] acc_y;
  logic [15:0] acc_z;
  logic        sample_valid;
  logic        overrun;
  logic        error;

  logic        m_busy;
  logic        hold_busy = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          lat = 2;
  bit          stall = 1'b0;
  logic [7:0]  mem [6];
  logic [6:0]  addr_q [$];
  logic [47:0] exp_q [$];

  imu_accel_sequencer #(
    .IMU_ADDR      (7'h68),
    .ACC_BASE_ADDR (7'h12),
    .SAMPLE_PERIOD (PERIOD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .i2c_start     (i2c_start),
    .i2c_read_write(i2c_read_write),
    .i2c_slave_addr(i2c_slave_addr),
    .i2c_reg_addr  (i2c_reg_addr),
    .i2c_data_in   (i2c_data_in),
    .i2c_data_out  (i2c_data_out),
    .i2c_busy      (i2c_busy),
    .i2c_done      (i2c_done),
    .acc_x         (acc_x),
    .acc_y         (acc_y),
    .acc_z         (acc_z),
    .sample_valid  (sample_valid),
    .overrun       (overrun),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i2c_busy = m_busy | hold_busy;

  function automatic logic [7:0] byte_for(input logic [6:0] a);
    int k;
    k = int'(a) - 18;
    if (k >= 0 && k < 6) return mem[k];
    return 8'hEE;
  endfunction

  function automatic logic [47:0] model_sample();
    return {mem[1], mem[0], mem[3], mem[2], mem[5], mem[4]};
  endfunction

  task automatic set_mem(input logic [47:0] b);
    for (int i = 0; i < 6; i++) mem[i] = b[47 - 8*i -: 8];
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(7'(7'h12 + i));
  endtask

  // Behavioural I2C master: accepts start, stays busy 'lat' cycles, pulses done
  initial begin
    bit         active;
    bit         prev_start;
    int         cnt;
    logic [6:0] a;
    logic [6:0] ea;
    active = 0; prev_start = 0; cnt = 0; a = '0;
    m_busy = 1'b0; i2c_done = 1'b0; i2c_data_out = 8'h00;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      if (i2c_start === 1'b1) begin
        start_cnt++;
        checks++;
        if (prev_start || active) begin
          errors++;
          $display("[TB] FAIL start_pulse got width>1 or start while busy (prev=%0b busy=%0b) required single pulse when idle", prev_start, active);
        end
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          checks++;
          if (i2c_reg_addr !== ea) begin
            errors++;
            $display("[TB] FAIL reg_addr got %h required %h", i2c_reg_addr, ea);
          end
        end
        if (!active) begin
          active = 1; m_busy = 1'b1; cnt = lat; a = i2c_reg_addr;
        end
      end else if (active) begin
        if (cnt > 0) cnt--;
        else if (!stall) begin
          i2c_done = 1'b1; i2c_data_out = byte_for(a); m_busy = 1'b0; active = 0;
        end
      end
      prev_start = (i2c_start === 1'b1);
    end
  end

  // Sample scoreboard: every valid strobe must match the oldest expected sample
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_valid got %h_%h_%h required no strobe", acc_x, acc_y, acc_z);
        end else begin
          e = exp_q.pop_front();
          if ({acc_x, acc_y, acc_z} !== e) begin
            errors++;
            $display("[TB] FAIL sample got %h_%h_%h required %h_%h_%h", acc_x, acc_y, acc_z, e[47:32], e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  task automatic wait_valid(input int budget, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s_valid_wait got no strobe within %0d cycles required strobe", tag, budget);
    end
  endtask

  task automatic wait_start(input logic [6:0] a, input int budget, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (i2c_start === 1'b1 && i2c_reg_addr === a) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s_start_wait got no start for %h within %0d cycles", tag, a, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2c_start, i2c_read_write, i2c_slave_addr, i2c_reg_addr, i2c_data_in} !== {1'b0, 1'b1, 7'h68, 7'h00, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_bus got %b %b %h %h %h required 0 1 68 00 00", i2c_start, i2c_read_write, i2c_slave_addr, i2c_reg_addr, i2c_data_in);
    end
    checks++;
    if ({acc_x, acc_y, acc_z} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL reset_acc got %h_%h_%h required 0", acc_x, acc_y, acc_z);
    end
    checks++;
    if ({sample_valid, overrun, error} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b required 000", {sample_valid, overrun, error});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal_burst();
    int s0;
    lat = 2;
    set_mem(48'h01_02_03_04_05_06);
    push_addrs(6);
    exp_q.push_back(48'h0201_0403_0605);
    s0 = start_cnt;
    enable = 1'b1;
    wait_valid(PERIOD + 200, "normal");
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL normal_valid_width got %b required 0", sample_valid);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 6) begin
      errors++;
      $display("[TB] FAIL normal_start_count got %0d required 6", start_cnt - s0);
    end
    checks++;
    if (acc_x !== 16'h0201 || addr_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL normal_state got acc_x=%h addr_left=%0d exp_left=%0d required 0201 0 0", acc_x, addr_q.size(), exp_q.size());
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL normal_overrun got %b required 0", overrun);
    end
  endtask

  task automatic test_busy_hold();
    int  s0;
    bit  seen;
    lat = 1;
    hold_busy = 1'b1;
    set_mem(48'hF0_80_34_12_FF_FF);
    push_addrs(6);
    exp_q.push_back(model_sample());
    s0 = start_cnt;
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < PERIOD + 50 && !seen; i++) begin
      @(negedge clk);
      if (i2c_reg_addr === 7'h12) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL busy_issue_wait got reg_addr %h required 12", i2c_reg_addr);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (i2c_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_hold_start cycle %0d got %b required 0", i, i2c_start);
      end
    end
    hold_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (i2c_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_release_start got %b required 1", i2c_start);
    end
    wait_valid(300, "busy");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 6 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL busy_burst got starts=%0d exp_left=%0d required 6 0", start_cnt - s0, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int s0;
    lat = 300;
    set_mem(48'hA1_B2_C3_D4_E5_F6);
    push_addrs(6);
    push_addrs(6);
    exp_q.push_back(model_sample());
    exp_q.push_back(model_sample());
    s0 = start_cnt;
    enable = 1'b1;
    wait_valid(2600, "overrun_first");
    wait_valid(2600, "overrun_second");
    enable = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_flag got %b required 1", overrun);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 12 || addr_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL overrun_bursts got starts=%0d addr_left=%0d exp_left=%0d required 12 0 0", start_cnt - s0, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_enable_drop();
    int          s0;
    logic [47:0] prev;
    lat = 5;
    prev = {acc_x, acc_y, acc_z};
    set_mem(48'h10_20_30_40_50_60);
    push_addrs(4);
    s0 = start_cnt;
    enable = 1'b1;
    wait_start(7'h15, PERIOD + 100, "drop");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 4) begin
      errors++;
      $display("[TB] FAIL drop_start_count got %0d required 4", start_cnt - s0);
    end
    checks++;
    if ({acc_x, acc_y, acc_z} !== prev) begin
      errors++;
      $display("[TB] FAIL drop_acc_hold got %h_%h_%h required %h", acc_x, acc_y, acc_z, prev);
    end
    checks++;
    if (i2c_busy !== 1'b0 || addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drop_byte_complete got busy=%b addr_left=%0d required 0 0", i2c_busy, addr_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int s0;
    lat = 20;
    push_addrs(1);
    s0 = start_cnt;
    enable = 1'b1;
    wait_start(7'h12, PERIOD + 50, "rst");
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({i2c_start, i2c_read_write, i2c_slave_addr, i2c_reg_addr, sample_valid, overrun, error} !== {1'b0, 1'b1, 7'h68, 7'h00, 3'b000}) begin
      errors++;
      $display("[TB] FAIL rst_async_bus got %b %b %h %h %b%b%b required 0 1 68 00 000", i2c_start, i2c_read_write, i2c_slave_addr, i2c_reg_addr, sample_valid, overrun, error);
    end
    checks++;
    if ({acc_x, acc_y, acc_z} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL rst_async_acc got %h_%h_%h required 0", acc_x, acc_y, acc_z);
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if ({acc_x, acc_y, acc_z} !== 48'h0 || start_cnt - s0 != 1) begin
      errors++;
      $display("[TB] FAIL rst_stale_done got acc=%h_%h_%h starts=%0d required 0 1", acc_x, acc_y, acc_z, start_cnt - s0);
    end
  endtask

  task automatic test_recovery();
    int s0;
    lat = 0;
    set_mem(48'h5A_A5_00_80_7F_01);
    push_addrs(6);
    exp_q.push_back(48'hA55A_8000_017F);
    s0 = start_cnt;
    enable = 1'b1;
    wait_valid(PERIOD + 200, "recovery");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 6 || exp_q.size() != 0 || overrun !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL recovery got starts=%0d exp_left=%0d overrun=%b error=%b required 6 0 0 0", start_cnt - s0, exp_q.size(), overrun, error);
    end
  endtask

`ifdef IMU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int s0;
    bit got;
    lat = 0;
    stall = 1'b1;
    push_addrs(1);
    s0 = start_cnt;
    enable = 1'b1;
    wait_start(7'h12, PERIOD + 50, "timeout");
    repeat (48) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early got error=%b required 0", error);
    end
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      @(negedge clk);
      if (error === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL timeout_flag got error=%b required 1", error);
    end
    stall = 1'b0;
    push_addrs(6);
    exp_q.push_back(model_sample());
    wait_valid(PERIOD + 300, "timeout_retry");
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear got error=%b required 0", error);
    end
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 7 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout_retry_count got starts=%0d exp_left=%0d required 7 0", start_cnt - s0, exp_q.size());
    end
  endtask
`endif

  // Scenario sequence
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 6; i++) mem[i] = 8'h00;
    test_reset();
    test_normal_burst();
    test_busy_hold();
    test_overrun();
    test_enable_drop();
    test_reset_mid_burst();
    test_recovery();
`ifdef IMU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog got no completion required finish before limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
